riscv_vec_alu_iter: RTL and testbench
=====================================

Name: riscv_vec_alu_iter

Overview:
- Parametrised, multi-cycle vector ALU for the riscvvec datapath.
- Generalises the single-cycle 8×32 vector ALU in three ways:
  - configurable element count, element width and lanes processed per cycle;
  - a real vector-length counter and per-element mask;
  - val/rdy request and response handshakes.
- Operands are latched on accept and processed LANES elements per cycle. The packed result is held until the consumer takes it.
- Sits between the vector register-file read stage and vector writeback.

Parameters:
- NELEM, 8, maximum vector length in elements.
- ELEM_W, 32, element width in bits.
- LANES, 2, elements computed per cycle. NELEM must be a multiple of LANES.
- VL_W, $clog2(NELEM)+1, width of the vector-length field.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req_val  input  1  request valid
- req_rdy  output  1  request ready
- req_fn  input  5  operation: fn[4] = scalar-operand mode, fn[3:0] = opcode
- req_a  input  NELEM*ELEM_W  operand A, element i in bits [i*ELEM_W +: ELEM_W]
- req_b  input  NELEM*ELEM_W  operand B; in scalar mode only element 0 is used, broadcast to all elements
- req_vl  input  VL_W  vector length
- req_vm  input  NELEM  element mask, bit i enables element i
- resp_val  output  1  result valid
- resp_rdy  input  1  consumer ready
- resp_out  output  NELEM*ELEM_W  packed result
- resp_err  output  1  illegal opcode flag

Behaviour:
- Clock and reset:
  - Single clock clk.
  - Reset is synchronous and active-high on reset.
- Reset state:
  - FSM goes to IDLE.
  - req_rdy=1, resp_val=0, resp_err=0, resp_out=0.
  - Chunk counter cleared.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - req_rdy=1.
  - On req_val, latch fn/a/b/vm, clear the result register and resp_err, and set the effective length to vl_eff = min(req_vl, NELEM).
  - If vl_eff=0, go to DONE; otherwise go to BUSY with chunk counter = 0.
- BUSY:
  - req_rdy=0.
  - Each cycle computes elements k*LANES .. k*LANES+LANES-1 and writes them into the result register, where k is the chunk counter.
  - When (k+1)*LANES >= vl_eff, go to DONE; otherwise increment k.
  - Number of BUSY cycles = ceil(vl_eff/LANES).
- DONE:
  - resp_val=1; resp_out and resp_err are stable.
  - On resp_rdy, go to IDLE.
  - A new request is not accepted in the same cycle as the response is taken; it is accepted on the following cycle.
- Latency:
  - Let the accept cycle be cycle 0.
  - resp_val first asserts in cycle 1+ceil(vl_eff/LANES).
  - Throughput is one vector per (2+ceil(vl_eff/LANES)) cycles when resp_rdy is held at 1.
- Element result rules:
  - Element i with i >= vl_eff, or with vm[i]=0, produces 0.
  - Operand B element = b[0 +: ELEM_W] when fn[4]=1, otherwise b[i*ELEM_W +: ELEM_W].
- Opcodes (fn[3:0]); all arithmetic is mod 2^ELEM_W:
  - 0 ADD: a+b
  - 1 SUB: a-b
  - 2 SLT: signed a<b, result 1 or 0
  - 3 SEQ: a==b, result 1 or 0
  - 4 AND: a&b
  - 5 OR: a|b
  - 6 XOR: a^b
  - 7 NOR: ~(a|b)
  - 11 SLTU: unsigned a<b, result 1 or 0
- Illegal opcodes:
  - Codes 12-15 are illegal, as are 8-10 when the shift feature is disabled.
  - An illegal opcode produces all-zero elements and resp_err=1.
  - Latency is unchanged.
- Timing paths: no combinational path from req_* to resp_* or from resp_rdy to req_rdy.
- Reset mid-operation: reset in BUSY or DONE aborts immediately. The next cycle is IDLE and no response is delivered.
- Backpressure: resp_rdy=0 in DONE holds all outputs indefinitely.

Optional Feature:
- Macro: RISCV_VEC_ALU_SHIFT_EN.
- Defined: opcodes 8 SLL, 9 SRL and 10 SRA are legal.
  - A is the shifted operand; the shift amount is b[$clog2(ELEM_W)-1:0] of the element, or of the broadcast scalar in scalar mode.
  - SRA is arithmetic.
- Undefined: opcodes 8-10 are illegal and follow the illegal-opcode rule (zeros, resp_err=1).
- The shift logic is absent from the netlist.

Test Plan:
- ADD, NELEM=8, LANES=2, a[i]=i, b[i]=10, vl=8, vm=0xFF, accept in cycle 0 -> resp_val first high in cycle 5, elements 10..17, resp_err=0.
- SUB in scalar mode, a[i]=100*i, b[0]=50, vl=5, vm=0xFB -> elements {0xFFFFFFCE, 50, 0, 250, 350, 0, 0, 0}, resp_val in cycle 4.
- SLT/SLTU with a[0]=0xFFFFFFFF, b[0]=1, vl=1 -> SLT element0=1; SLTU element0=0. vl=0 -> resp_val in cycle 1 with all zeros.
- Backpressure: resp_rdy=0 for 6 cycles in DONE -> resp_out stable, req_rdy=0. Assert resp_rdy -> IDLE next cycle; a back-to-back request is accepted then.
- Reset asserted in the 2nd BUSY cycle -> IDLE, resp_val=0, req_rdy=1 the next cycle; a following ADD completes correctly.
- fn=9 (SRL), a[i]=0x80000000, b[i]=4 -> with RISCV_VEC_ALU_SHIFT_EN: 0x08000000, resp_err=0; without: zeros, resp_err=1.

Source files
------------

// File: rtl/riscv_vec_alu_iter.sv
// riscv_vec_alu_iter: multi-cycle vector ALU between vector register-file
// read and vector writeback.
//
// On accept, operands are latched and the result register is cleared. The
// vector is then processed LANES elements per cycle. The packed result is
// held in DONE until the consumer takes it.
//
// Elements at or beyond the effective vector length, or with a clear mask
// bit, produce zero. Illegal opcodes produce all-zero elements and raise
// resp_err; latency is the same as for a legal opcode.
//
// Optional feature macro: RISCV_VEC_ALU_SHIFT_EN
//   Defined:   opcodes 8 SLL, 9 SRL and 10 SRA are legal.
//   Undefined: opcodes 8-10 are illegal, and no shift logic is built.
//
// Ports:
//   clk       clock
//   reset     synchronous active-high reset
//   req_val   request valid
//   req_rdy   request ready (high only in IDLE)
//   req_fn    [4] scalar-operand mode, [3:0] opcode
//   req_a     operand A, element i at [i*ELEM_W +: ELEM_W]
//   req_b     operand B; in scalar mode element 0 is broadcast
//   req_vl    requested vector length (clamped to NELEM)
//   req_vm    per-element enable mask
//   resp_val  result valid (DONE state)
//   resp_rdy  consumer ready
//   resp_out  packed result
//   resp_err  illegal-opcode flag
module riscv_vec_alu_iter #(
  parameter int NELEM  = 8,
  parameter int ELEM_W = 32,
  parameter int LANES  = 2,
  parameter int VL_W   = $clog2(NELEM) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_val,
  output logic                      req_rdy,
  input  logic [4:0]                req_fn,
  input  logic [NELEM*ELEM_W-1:0]   req_a,
  input  logic [NELEM*ELEM_W-1:0]   req_b,
  input  logic [VL_W-1:0]           req_vl,
  input  logic [NELEM-1:0]          req_vm,
  output logic                      resp_val,
  input  logic                      resp_rdy,
  output logic [NELEM*ELEM_W-1:0]   resp_out,
  output logic                      resp_err
);

  localparam int NCHUNK = NELEM / LANES;
  localparam int K_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int SH_W   = (ELEM_W > 1) ? $clog2(ELEM_W) : 1;
  localparam int VEC_W  = NELEM * ELEM_W;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [4:0]         fn_r;
  logic [VEC_W-1:0]   a_r;
  logic [VEC_W-1:0]   b_r;
  logic [VEC_W-1:0]   result_r;
  logic [VEC_W-1:0]   result_next_s;
  logic [NELEM-1:0]   vm_r;
  logic [VL_W-1:0]    vl_eff_r;
  logic [VL_W-1:0]    req_vl_eff_s;
  logic [K_W-1:0]     k_r;
  logic               err_r;
  logic               last_chunk_s;
  logic [31:0]        chunk_end_s;

  // Legality of an opcode; shift codes are legal only with the shift feature.
  function automatic logic op_illegal(input logic [3:0] op);
    logic ill;
    case (op)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd11: ill = 1'b0;
`ifdef RISCV_VEC_ALU_SHIFT_EN
      4'd8, 4'd9, 4'd10: ill = 1'b0;
`endif
      default: ill = 1'b1;
    endcase
    return ill;
  endfunction

  // Single-element operation, arithmetic mod 2^ELEM_W.
  function automatic logic [ELEM_W-1:0] alu_elem(input logic [3:0]        op,
                                                  input logic [ELEM_W-1:0] a,
                                                  input logic [ELEM_W-1:0] b);
    logic [ELEM_W-1:0] r;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = {{(ELEM_W-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd3:  r = {{(ELEM_W-1){1'b0}}, (a == b)};
      4'd4:  r = a & b;
      4'd5:  r = a | b;
      4'd6:  r = a ^ b;
      4'd7:  r = ~(a | b);
`ifdef RISCV_VEC_ALU_SHIFT_EN
      4'd8:  r = a << b[SH_W-1:0];
      4'd9:  r = a >> b[SH_W-1:0];
      4'd10: r = $signed(a) >>> b[SH_W-1:0];
`endif
      4'd11: r = {{(ELEM_W-1){1'b0}}, (a < b)};
      default: r = {ELEM_W{1'b0}};
    endcase
    return r;
  endfunction

  assign req_vl_eff_s = (req_vl > VL_W'(NELEM)) ? VL_W'(NELEM) : req_vl;
  assign chunk_end_s  = (32'(k_r) + 32'd1) * 32'(LANES);
  assign last_chunk_s = (chunk_end_s >= 32'(vl_eff_r));

  // State decode drives the handshakes, so no input reaches an output combinationally.
  assign req_rdy  = (state_r == IDLE);
  assign resp_val = (state_r == DONE);
  assign resp_out = result_r;
  assign resp_err = err_r;

  // Result register with the current chunk's LANES elements merged in.
  always_comb begin
    result_next_s = result_r;
    for (int l = 0; l < LANES; l++) begin
      int                idx;
      logic [ELEM_W-1:0] a_el;
      logic [ELEM_W-1:0] b_el;
      idx  = int'(k_r) * LANES + l;
      a_el = a_r[idx*ELEM_W +: ELEM_W];
      if (fn_r[4]) begin
        b_el = b_r[ELEM_W-1:0];
      end else begin
        b_el = b_r[idx*ELEM_W +: ELEM_W];
      end
      if ((idx < int'(vl_eff_r)) && vm_r[idx] && !op_illegal(fn_r[3:0])) begin
        result_next_s[idx*ELEM_W +: ELEM_W] = alu_elem(fn_r[3:0], a_el, b_el);
      end else begin
        result_next_s[idx*ELEM_W +: ELEM_W] = {ELEM_W{1'b0}};
      end
    end
  end

  // Next-state logic: IDLE accepts, BUSY walks chunks, DONE waits for the consumer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_val) begin
          state_next_s = (req_vl_eff_s == {VL_W{1'b0}}) ? DONE : BUSY;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY: begin
        if (last_chunk_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = BUSY;
        end
      end
      DONE: begin
        if (resp_rdy) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand latch, chunk counter, result and error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fn_r     <= 5'd0;
      a_r      <= {VEC_W{1'b0}};
      b_r      <= {VEC_W{1'b0}};
      vm_r     <= {NELEM{1'b0}};
      vl_eff_r <= {VL_W{1'b0}};
      k_r      <= {K_W{1'b0}};
      result_r <= {VEC_W{1'b0}};
      err_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_val) begin
            fn_r     <= req_fn;
            a_r      <= req_a;
            b_r      <= req_b;
            vm_r     <= req_vm;
            vl_eff_r <= req_vl_eff_s;
            k_r      <= {K_W{1'b0}};
            result_r <= {VEC_W{1'b0}};
            // A zero-length vector goes straight to DONE, so the flag is settled now.
            err_r    <= (req_vl_eff_s == {VL_W{1'b0}}) ? op_illegal(req_fn[3:0]) : 1'b0;
          end
        end
        BUSY: begin
          result_r <= result_next_s;
          if (last_chunk_s) begin
            err_r <= op_illegal(fn_r[3:0]);
          end else begin
            k_r <= k_r + K_W'(1'b1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_vec_alu_iter.sv
module tb_riscv_vec_alu_iter;

  localparam int NE  = 8;
  localparam int W   = 32;
  localparam int L   = 2;
  localparam int VLW = 4;
  localparam int VW  = NE * W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_val = 1'b0;
  logic          req_rdy;
  logic [4:0]    req_fn = 5'd0;
  logic [VW-1:0] req_a = '0;
  logic [VW-1:0] req_b = '0;
  logic [VLW-1:0] req_vl = '0;
  logic [NE-1:0] req_vm = '0;
  logic          resp_val;
  logic          resp_rdy = 1'b1;
  logic [VW-1:0] resp_out;
  logic          resp_err;

  int checks = 0;
  int failures = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready

  // reference-model state for the compare process
  int            cyc = 0;
  bit            started = 0;
  bit            pending = 0;
  int            due = 0;
  logic [VW-1:0] exp_out;
  logic          exp_err;

  riscv_vec_alu_iter #(.NELEM(NE), .ELEM_W(W), .LANES(L), .VL_W(VLW)) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_fn(req_fn),
    .req_a(req_a), .req_b(req_b), .req_vl(req_vl), .req_vm(req_vm),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_out(resp_out), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Whole-vector reference computed directly from the element rules.
  function automatic void model(input logic [4:0] fn, input logic [VW-1:0] a, input logic [VW-1:0] b,
                                input logic [VLW-1:0] vl, input logic [NE-1:0] vm,
                                output logic [VW-1:0] out, output logic err, output int lat);
    int vle;
    bit legal;
    int op;
    op = int'(fn[3:0]);
    vle = (int'(vl) > NE) ? NE : int'(vl);
    lat = 1 + (vle + L - 1) / L;
    legal = (op <= 7) || (op == 11);
`ifdef RISCV_VEC_ALU_SHIFT_EN
    if (op >= 8 && op <= 10) legal = 1;
`endif
    err = !legal;
    out = '0;
    for (int i = 0; i < NE; i++) begin
      logic [W-1:0] ae, be, r;
      ae = a[i*W +: W];
      be = fn[4] ? b[W-1:0] : b[i*W +: W];
      r = '0;
      if (legal && i < vle && vm[i]) begin
        case (op)
          0: r = ae + be;
          1: r = ae - be;
          2: r = ($signed(ae) < $signed(be)) ? 32'd1 : 32'd0;
          3: r = (ae == be) ? 32'd1 : 32'd0;
          4: r = ae & be;
          5: r = ae | be;
          6: r = ae ^ be;
          7: r = ~(ae | be);
          8: r = ae << be[4:0];
          9: r = ae >> be[4:0];
          10: r = $signed(ae) >>> be[4:0];
          11: r = (ae < be) ? 32'd1 : 32'd0;
          default: r = '0;
        endcase
      end
      out[i*W +: W] = r;
    end
  endfunction

  // Consumer-ready driver, changes 2 time units after each rising edge.
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0: resp_rdy = 1'b1;
      1: resp_rdy = ($urandom_range(0, 2) != 0);
      default: resp_rdy = 1'b0;
    endcase
  end

  // Cycle-by-cycle comparison of the DUT against the transaction model.
  always @(negedge clk) begin
    bit exp_val;
    int lat;
    cyc++;
    if (reset) begin
      pending = 0;
      started = 1;
    end else if (started) begin
      exp_val = pending && (cyc >= due);
      chk("req_rdy", {255'd0, req_rdy}, {255'd0, !pending});
      chk("resp_val", {255'd0, resp_val}, {255'd0, exp_val});
      if (exp_val) begin
        chk("resp_out", resp_out, exp_out);
        chk("resp_err", {255'd0, resp_err}, {255'd0, exp_err});
      end
      if (exp_val && resp_rdy) begin
        pending = 0;
      end else if (!pending && req_val) begin
        model(req_fn, req_a, req_b, req_vl, req_vm, exp_out, exp_err, lat);
        due = cyc + lat;
        pending = 1;
      end
    end
  end

  // Drive one request from posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(input logic [4:0] fn, input logic [VW-1:0] a, input logic [VW-1:0] b,
                      input logic [VLW-1:0] vl, input logic [NE-1:0] vm, output int waited);
    req_fn = fn; req_a = a; req_b = b; req_vl = vl; req_vm = vm; req_val = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (req_rdy) break;
      waited++;
      if (waited > 60) begin
        chk("accept_timeout", 256'd1, 256'd0);
        break;
      end
    end
    @(posedge clk); #1;
    req_val = 1'b0;
    req_a = ~req_a; req_b = ~req_b; req_vm = ~req_vm;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pending && n < 100);
    if (pending) chk("idle_timeout", 256'd1, 256'd0);
    @(posedge clk); #1;
  endtask

  // Directed transaction with hand-computed latency and result.
  task automatic lit(input string name, input logic [4:0] fn, input logic [VW-1:0] a, input logic [VW-1:0] b,
                     input logic [VLW-1:0] vl, input logic [NE-1:0] vm,
                     input int exp_lat, input logic [VW-1:0] exp_v, input logic exp_e);
    int waited, lat;
    send(fn, a, b, vl, vm, waited);
    lat = 1;
    forever begin
      @(negedge clk);
      if (resp_val || lat > 40) break;
      lat++;
    end
    chk({name, "_lat"}, VW'(lat), VW'(exp_lat));
    chk({name, "_out"}, resp_out, exp_v);
    chk({name, "_err"}, {255'd0, resp_err}, {255'd0, exp_e});
    wait_idle();
  endtask

  initial begin
    logic [VW-1:0] va, vb, ve, cap;
    int waited, n;
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] va, vb, ve, cap;
    int waited, n;
    int legal_ops[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 11};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_req_rdy", {255'd0, req_rdy}, 256'd1);
    chk("rst_resp_val", {255'd0, resp_val}, 256'd0);
    chk("rst_resp_out", resp_out, 256'd0);
    chk("rst_resp_err", {255'd0, resp_err}, 256'd0);
    @(posedge clk); #1;

    // ADD, full length
    for (int i = 0; i < NE; i++) begin va[i*W +: W] = i; vb[i*W +: W] = 10; ve[i*W +: W] = 10 + i; end
    lit("add", 5'd0, va, vb, 4'd8, 8'hFF, 5, ve, 1'b0);

    // SUB scalar, vl=5, element 2 masked
    for (int i = 0; i < NE; i++) begin va[i*W +: W] = 100 * i; vb[i*W +: W] = 32'h1234; end
    vb[W-1:0] = 32'd50;
    ve = '0;
    ve[0*W +: W] = 32'hFFFFFFCE; ve[1*W +: W] = 32'd50; ve[3*W +: W] = 32'd250; ve[4*W +: W] = 32'd350;
    lit("sub_scalar", 5'b10001, va, vb, 4'd5, 8'hFB, 4, ve, 1'b0);

    // SLT / SLTU, vl=1; then vl=0
    va = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 32'hFFFFFFFF};
    vb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 32'd1};
    lit("slt", 5'd2, va, vb, 4'd1, 8'hFF, 2, 256'd1, 1'b0);
    lit("sltu", 5'd11, va, vb, 4'd1, 8'hFF, 2, 256'd0, 1'b0);
    lit("vl0", 5'd0, va, vb, 4'd0, 8'hFF, 1, 256'd0, 1'b0);
    lit("illegal", 5'd13, va, vb, 4'd8, 8'hFF, 5, 256'd0, 1'b1);

    // SRL
    for (int i = 0; i < NE; i++) begin va[i*W +: W] = 32'h80000000; vb[i*W +: W] = 32'd4; end
`ifdef RISCV_VEC_ALU_SHIFT_EN
    for (int i = 0; i < NE; i++) ve[i*W +: W] = 32'h08000000;
    lit("srl", 5'd9, va, vb, 4'd8, 8'hFF, 5, ve, 1'b0);
`else
    lit("srl", 5'd9, va, vb, 4'd8, 8'hFF, 5, 256'd0, 1'b1);
`endif

    // Backpressure in DONE, then back-to-back request
    rdy_mode = 2;
    @(posedge clk); #1;
    for (int i = 0; i < NE; i++) begin va[i*W +: W] = $urandom; vb[i*W +: W] = $urandom; end
    send(5'd6, va, vb, 4'd4, 8'hFF, waited);
    n = 0;
    while (!resp_val && n < 40) begin @(negedge clk); n++; end
    cap = resp_out;
    repeat (6) begin
      @(negedge clk);
      chk("bp_stable", resp_out, cap);
      chk("bp_req_rdy", {255'd0, req_rdy}, 256'd0);
      chk("bp_resp_val", {255'd0, resp_val}, 256'd1);
    end
    @(posedge clk); #1;
    rdy_mode = 0;
    send(5'd0, va, vb, 4'd8, 8'hFF, waited);
    chk("b2b_accept_wait", VW'(waited), VW'(1));
    wait_idle();

    // Reset in the second BUSY cycle
    send(5'd0, va, vb, 4'd8, 8'hFF, waited);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_resp_val", {255'd0, resp_val}, 256'd0);
    chk("abort_req_rdy", {255'd0, req_rdy}, 256'd1);
    @(posedge clk); #1;
    for (int i = 0; i < NE; i++) begin va[i*W +: W] = 7 * i; vb[i*W +: W] = 3; ve[i*W +: W] = 7 * i + 3; end
    lit("add_after_abort", 5'd0, va, vb, 4'd8, 8'hFF, 5, ve, 1'b0);

    // Randomised traffic, random consumer backpressure, back-to-back requests
    rdy_mode = 1;
    for (int t = 0; t < 200; t++) begin
      logic [4:0] fn;
      fn[4] = $urandom_range(0, 1);
      fn[3:0] = ($urandom_range(0, 4) != 0) ? 4'(legal_ops[$urandom_range(0, 8)]) : 4'($urandom_range(0, 15));
      for (int i = 0; i < NE; i++) begin
        va[i*W +: W] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
        vb[i*W +: W] = ($urandom_range(0, 3) == 0) ? va[i*W +: W] : $urandom;
      end
      send(fn, va, vb, 4'($urandom_range(0, 15)), 8'($urandom), waited);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rdy_mode = 0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
